// File: rtl/atari_bus_pkg.sv
// Shared types for the Atari 7800 cartridge write-capture block.
//   ADDR_W / DATA_W : bus widths
//   STAMP_W         : width of the optional phi2 cycle stamp
//   wr_entry_t      : one captured write {addr, data[, stamp]}
//   cap_state_t     : capture FSM states
// Optional feature macro: ATARI_WRCAP_STAMP_EN (adds the stamp field).
package atari_bus_pkg;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 8;
  localparam int STAMP_W = 16;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  data;
`ifdef ATARI_WRCAP_STAMP_EN
    logic [STAMP_W-1:0] stamp;
`endif
  } wr_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HIGH   = 2'd1,
    ST_COMMIT = 2'd2
  } cap_state_t;

endpackage

// File: rtl/atari_wr_fifo.sv
// Synchronous first-word-fall-through FIFO with registered head outputs.
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   push, push_data       : write request and entry
//   ready                 : consumer takes head when valid & ready
//   valid, head           : registered head-of-queue outputs
//   level                 : occupancy (extra-bit pointer difference)
//   overflow, overflow_clr: sticky drop flag and its synchronous clear
module atari_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 24
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     ready,
  output logic                     valid,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic                     overflow_clr
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam logic [PTR_W-1:0] FULL_LVL = PTR_W'(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             valid_q, valid_d;
  logic [W-1:0]     head_q, head_d;
  logic             ovf_q, ovf_d;

  logic [PTR_W-1:0] lvl_cur;
  logic             full;
  logic             do_pop;
  logic             do_push;
  logic             drop;

  assign lvl_cur = wr_ptr_q - rd_ptr_q;
  assign full    = (lvl_cur == FULL_LVL);
  assign do_pop  = valid_q & ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    valid_d  = 1'b0;
    head_d   = '0;
    ovf_d    = ovf_q;

    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    if (wr_ptr_d != rd_ptr_d) begin
      valid_d = 1'b1;
      // The pushed slot coincides with the new head slot only when the
      // pushed entry is the sole occupant; bypass the memory in that case.
      if (do_push && (wr_ptr_q[IDX_W-1:0] == rd_ptr_d[IDX_W-1:0]))
        head_d = push_data;
      else
        head_d = mem_q[rd_ptr_d[IDX_W-1:0]];
    end

    // Clear first so that a simultaneous drop wins.
    if (overflow_clr) ovf_d = 1'b0;
    if (drop)         ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[IDX_W-1:0]] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      valid_q  <= 1'b0;
      head_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      valid_q  <= valid_d;
      head_q   <= head_d;
      ovf_q    <= ovf_d;
    end
  end

  assign valid    = valid_q;
  assign head     = head_q;
  assign level    = lvl_cur;
  assign overflow = ovf_q;

endmodule

// File: rtl/atari_bus_write_capture.sv
// Cartridge-side receiver for Atari 7800 CPU write cycles. Samples the raw
// bus, recognises completed CPU writes inside an address window and queues
// them (address, data) for an internal consumer. Never drives the bus.
// Ports:
//   clk, rst_n                 : 27 MHz clock, async active-low reset
//   a, d_in, phi2, rw, halt    : raw Atari bus inputs
//   wr_valid, wr_ready         : head handshake
//   wr_addr, wr_data           : head entry
//   fifo_level                 : queue occupancy
//   overflow, overflow_clr     : sticky drop flag and clear
//   wr_stamp                   : head phi2-cycle stamp (ATARI_WRCAP_STAMP_EN only)
// Optional feature macro: ATARI_WRCAP_STAMP_EN.
module atari_bus_write_capture
  import atari_bus_pkg::*;
#(
  parameter logic [15:0] WIN_BASE      = 16'h4000,
  parameter logic [15:0] WIN_MASK      = 16'hC000,
  parameter int          FIFO_DEPTH    = 4,
  parameter int          MIN_PHI2_HIGH = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [15:0]                   a,
  input  logic [7:0]                    d_in,
  input  logic                          phi2,
  input  logic                          rw,
  input  logic                          halt,
  output logic                          wr_valid,
  input  logic                          wr_ready,
  output logic [15:0]                   wr_addr,
  output logic [7:0]                    wr_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          overflow_clr
`ifdef ATARI_WRCAP_STAMP_EN
  ,
  output logic [15:0]                   wr_stamp
`endif
);

  localparam int CNT_W = (MIN_PHI2_HIGH < 2) ? 1 : $clog2(MIN_PHI2_HIGH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MIN_PHI2_HIGH);
  localparam int ENTRY_W = $bits(wr_entry_t);

  // ---------------- input synchronizers ----------------
  logic        phi2_s1_q, phi2_s2_q;
  logic        rw_s1_q,   rw_s2_q;
  logic        halt_s1_q, halt_s2_q;
  logic [15:0] a_s1_q,    a_s2_q;
  logic [7:0]  d_s1_q,    d_s2_q;
  logic        phi2_s, rw_s, halt_s;
  logic [15:0] a_s;
  logic [7:0]  d_in_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phi2_s1_q <= 1'b0;
      phi2_s2_q <= 1'b0;
      rw_s1_q   <= 1'b1;
      rw_s2_q   <= 1'b1;
      halt_s1_q <= 1'b0;
      halt_s2_q <= 1'b0;
    end else begin
      phi2_s1_q <= phi2;
      phi2_s2_q <= phi2_s1_q;
      rw_s1_q   <= rw;
      rw_s2_q   <= rw_s1_q;
      halt_s1_q <= halt;
      halt_s2_q <= halt_s1_q;
    end
  end

  always_ff @(posedge clk) begin
    a_s1_q <= a;
    a_s2_q <= a_s1_q;
    d_s1_q <= d_in;
    d_s2_q <= d_s1_q;
  end

  assign phi2_s = phi2_s2_q;
  assign rw_s   = rw_s2_q;
  assign halt_s = halt_s2_q;
  assign a_s    = a_s2_q;
  assign d_in_s = d_s2_q;

  // ---------------- capture FSM ----------------
  cap_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      hold_a_q, hold_a_d;
  logic [7:0]       hold_d_q, hold_d_d;
  logic             hold_rw_q, hold_rw_d;
  logic             hold_load;
  logic             qual_fall;
  logic             push;
  logic             in_win;

  assign in_win = ((hold_a_q & WIN_MASK) == WIN_BASE);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hold_load = 1'b0;
    qual_fall = 1'b0;
    push      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // DMA cycles (halt_s low) are never entered.
        if (phi2_s && halt_s) begin
          state_d   = ST_HIGH;
          cnt_d     = CNT_W'(1);
          hold_load = 1'b1;
        end
      end
      ST_HIGH: begin
        if (!halt_s) begin
          // Maria took the bus mid-cycle: abandon without committing.
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (phi2_s) begin
          hold_load = 1'b1;
          if (cnt_q < CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        end else begin
          qual_fall = (cnt_q >= CNT_MAX);
          cnt_d     = '0;
          if (qual_fall && !hold_rw_q && in_win) state_d = ST_COMMIT;
          else                                   state_d = ST_IDLE;
        end
      end
      ST_COMMIT: begin
        push    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Hold registers track the last phi2-high sample before the fall.
  always_comb begin
    hold_a_d  = hold_a_q;
    hold_d_d  = hold_d_q;
    hold_rw_d = hold_rw_q;
    if (hold_load) begin
      hold_a_d  = a_s;
      hold_d_d  = d_in_s;
      hold_rw_d = rw_s;
    end
  end

  always_ff @(posedge clk) begin
    hold_a_q  <= hold_a_d;
    hold_d_q  <= hold_d_d;
    hold_rw_q <= hold_rw_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------- optional phi2 cycle stamp ----------------
  wr_entry_t push_entry;
  wr_entry_t head_entry;
  logic [ENTRY_W-1:0] head_bits;

`ifdef ATARI_WRCAP_STAMP_EN
  logic [15:0] stamp_cnt_q, stamp_cnt_d;
  logic [15:0] hold_stamp_q, hold_stamp_d;

  // The stamp is the count of qualified cycles before this one, so the
  // first write after reset carries 0.
  always_comb begin
    stamp_cnt_d  = stamp_cnt_q;
    hold_stamp_d = hold_stamp_q;
    if (qual_fall) begin
      stamp_cnt_d  = stamp_cnt_q + 16'd1;
      hold_stamp_d = stamp_cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stamp_cnt_q <= '0;
    else        stamp_cnt_q <= stamp_cnt_d;
  end

  always_ff @(posedge clk) begin
    hold_stamp_q <= hold_stamp_d;
  end

  always_comb begin
    push_entry.addr  = hold_a_q;
    push_entry.data  = hold_d_q;
    push_entry.stamp = hold_stamp_q;
  end
`else
  always_comb begin
    push_entry.addr = hold_a_q;
    push_entry.data = hold_d_q;
  end
`endif

  // ---------------- write queue ----------------
  atari_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push         (push),
    .push_data    (push_entry),
    .ready        (wr_ready),
    .valid        (wr_valid),
    .head         (head_bits),
    .level        (fifo_level),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  assign head_entry = wr_entry_t'(head_bits);
  assign wr_addr    = head_entry.addr;
  assign wr_data    = head_entry.data;
`ifdef ATARI_WRCAP_STAMP_EN
  assign wr_stamp   = head_entry.stamp;
`endif

endmodule

// File: tb/tb_atari_bus_write_capture.sv
// Self-checking bench for atari_bus_write_capture (default parameters:
// window $4000-$7FFF, depth 4, minimum phi2-high of 3 clocks).
module tb_atari_bus_write_capture;

  localparam int DEPTH = 4;
  localparam int MINHI = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] a = 16'h0000;
  logic [7:0]  d_in = 8'h00;
  logic        phi2 = 1'b0;
  logic        rw = 1'b1;
  logic        halt = 1'b1;
  logic        wr_valid;
  logic        wr_ready = 1'b0;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic [2:0]  fifo_level;
  logic        overflow;
  logic        overflow_clr = 1'b0;
`ifdef ATARI_WRCAP_STAMP_EN
  logic [15:0] wr_stamp;
`endif

  always #5 clk = ~clk;

  atari_bus_write_capture dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .a            (a),
    .d_in         (d_in),
    .phi2         (phi2),
    .rw           (rw),
    .halt         (halt),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
`ifdef ATARI_WRCAP_STAMP_EN
    ,
    .wr_stamp     (wr_stamp)
`endif
  );

  int checks = 0;
  int failures = 0;

  logic [23:0] mq[$];   // model queue of {addr, data}
  logic        movf;    // model overflow flag

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        rw;
    logic        halt;
    int          hi;
    bit          drop;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Capture rule from the bus protocol: long-enough, CPU-owned write in window.
  function automatic bit expect_capture(input vec_t v);
    return (v.hi >= MINHI) && (v.rw == 1'b0) && (v.halt == 1'b1) && !v.drop &&
           ((v.addr & 16'hC000) == 16'h4000);
  endfunction

  function automatic void model_cycle(input vec_t v, input bit popped);
    if (expect_capture(v)) begin
      if (popped && mq.size() > 0) void'(mq.pop_front());
      if (mq.size() < DEPTH) mq.push_back({v.addr, v.data});
      else movf = 1'b1;
    end
  endfunction

  // One bus cycle. pulse[0] raises wr_ready and pulse[1] raises overflow_clr
  // for exactly the clock edge on which a capture would be pushed.
  task automatic bus_cycle(input vec_t v, input logic [1:0] pulse);
    @(negedge clk);
    a = v.addr; d_in = v.data; rw = v.rw; halt = v.halt; phi2 = 1'b1;
    for (int k = 1; k <= v.hi; k++) begin
      @(negedge clk);
      if (v.drop && k == v.hi - 1) halt = 1'b0;
    end
    phi2 = 1'b0;
    repeat (3) @(negedge clk);
    wr_ready = pulse[0]; overflow_clr = pulse[1];
    @(negedge clk);
    wr_ready = 1'b0; overflow_clr = 1'b0;
    repeat (2) @(negedge clk);
    halt = 1'b1; rw = 1'b1;
  endtask

  task automatic drain(input string nm);
    int guard;
    guard = 0;
    while (mq.size() > 0 && guard < 32) begin
      chk({nm, "_valid"}, 32'(wr_valid), 32'd1);
      chk({nm, "_head"}, 32'({wr_addr, wr_data}), 32'(mq[0]));
      wr_ready = 1'b1;
      @(negedge clk);
      wr_ready = 1'b0;
      void'(mq.pop_front());
      guard++;
    end
    chk({nm, "_empty_valid"}, 32'(wr_valid), 32'd0);
    chk({nm, "_empty_level"}, 32'(fifo_level), 32'd0);
  endtask

  function automatic vec_t mk(input logic [15:0] ad, input logic [7:0] dd, input logic r,
                              input logic h, input int hi, input bit dr);
    vec_t v;
    v.addr = ad; v.data = dd; v.rw = r; v.halt = h; v.hi = hi; v.drop = dr;
    return v;
  endfunction

  initial begin
    vec_t v;
    logic [15:0] ra;
    int exp_lvl;

    tbl[0] = mk(16'h4123, 8'h5A, 1'b0, 1'b1, 8, 1'b0);  // basic write
    tbl[1] = mk(16'h4123, 8'h5A, 1'b1, 1'b1, 8, 1'b0);  // read
    tbl[2] = mk(16'h2000, 8'h11, 1'b0, 1'b1, 8, 1'b0);  // below window
    tbl[3] = mk(16'h8000, 8'h11, 1'b0, 1'b1, 2, 1'b0);  // glitch, out of window
    tbl[4] = mk(16'h4001, 8'h22, 1'b0, 1'b1, 2, 1'b0);  // glitch in window
    tbl[5] = mk(16'h4002, 8'h33, 1'b0, 1'b1, 3, 1'b0);  // minimum width
    tbl[6] = mk(16'h4003, 8'h44, 1'b0, 1'b1, 8, 1'b1);  // halt falls mid-cycle
    tbl[7] = mk(16'h4004, 8'h55, 1'b0, 1'b0, 8, 1'b0);  // DMA cycle
    tbl[8] = mk(16'h7FFF, 8'h66, 1'b0, 1'b1, 4, 1'b0);  // top of window
    tbl[9] = mk(16'hC000, 8'h77, 1'b0, 1'b1, 4, 1'b0);  // above window
    movf = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(wr_valid), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_addr", 32'(wr_addr), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // write latency: wr_valid on the 4th edge after the raw fall is sampled
    a = 16'h4123; d_in = 8'h5A; rw = 1'b0; halt = 1'b1; phi2 = 1'b1;
    repeat (8) @(negedge clk);
    phi2 = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("lat_edge3_valid", 32'(wr_valid), 32'd0);
    @(posedge clk);
    #1 chk("lat_edge4_valid", 32'(wr_valid), 32'd1);
    chk("lat_addr", 32'(wr_addr), 32'h4123);
    chk("lat_data", 32'(wr_data), 32'h5A);
    chk("lat_level", 32'(fifo_level), 32'd1);
    @(negedge clk);
    rw = 1'b1;
    mq.push_back({16'h4123, 8'h5A});
    drain("lat_drain");

    // table-driven single cycles
    for (int i = 0; i < 10; i++) begin
      bus_cycle(tbl[i], 2'b00);
      exp_lvl = expect_capture(tbl[i]) ? 1 : 0;
      chk($sformatf("tbl%0d_level", i), 32'(fifo_level), 32'(exp_lvl));
      if (exp_lvl == 1) mq.push_back({tbl[i].addr, tbl[i].data});
      drain($sformatf("tbl%0d", i));
    end

    // data changes during phi2 high: last sampled value is kept
    @(negedge clk);
    a = 16'h4456; d_in = 8'h33; rw = 1'b0; phi2 = 1'b1;
    repeat (4) @(negedge clk);
    a = 16'h4457; d_in = 8'h77;
    repeat (4) @(negedge clk);
    phi2 = 1'b0;
    repeat (6) @(negedge clk);
    rw = 1'b1;
    mq.push_back({16'h4457, 8'h77});
    drain("late_data");

    // overflow: 5 writes into depth 4
    for (int i = 0; i < 5; i++) begin
      v = mk(16'h4000 + 16'(i), 8'h40 + 8'(i), 1'b0, 1'b1, 8, 1'b0);
      bus_cycle(v, 2'b00);
      model_cycle(v, 1'b0);
    end
    chk("ovf_level", 32'(fifo_level), 32'd4);
    chk("ovf_set", 32'(overflow), 32'd1);
    overflow_clr = 1'b1;
    @(negedge clk);
    overflow_clr = 1'b0;
    movf = 1'b0;
    chk("ovf_clr", 32'(overflow), 32'd0);
    drain("ovf_drain");

    // full FIFO with push and pop on the same edge
    for (int i = 0; i < 4; i++) begin
      v = mk(16'h4000 + 16'(i), 8'h40 + 8'(i), 1'b0, 1'b1, 8, 1'b0);
      bus_cycle(v, 2'b00);
      model_cycle(v, 1'b0);
    end
    v = mk(16'h4010, 8'h45, 1'b0, 1'b1, 8, 1'b0);
    bus_cycle(v, 2'b01);
    model_cycle(v, 1'b1);
    chk("pp_level", 32'(fifo_level), 32'd4);
    chk("pp_ovf", 32'(overflow), 32'd0);
    chk("pp_head", 32'(wr_data), 32'h41);
    // drop while overflow_clr is asserted on the same edge: set wins
    v = mk(16'h4011, 8'h46, 1'b0, 1'b1, 8, 1'b0);
    bus_cycle(v, 2'b10);
    model_cycle(v, 1'b0);
    chk("setwins_ovf", 32'(overflow), 32'd1);
    overflow_clr = 1'b1;
    @(negedge clk);
    overflow_clr = 1'b0;
    movf = 1'b0;
    drain("pp_drain");

    // randomized cycles against the model
    for (int i = 0; i < 48; i++) begin
      ra = 16'($urandom);
      if ($urandom_range(0, 1) == 1) ra[15:14] = 2'b01;
      v = mk(ra, 8'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) != 0),
             int'($urandom_range(1, 6)), 1'b0);
      v.drop = (v.hi >= 2) && ($urandom_range(0, 5) == 0);
      bus_cycle(v, 2'b00);
      model_cycle(v, 1'b0);
      chk($sformatf("rnd%0d_level", i), 32'(fifo_level), 32'(mq.size()));
      chk($sformatf("rnd%0d_ovf", i), 32'(overflow), 32'(movf));
      if (i % 8 == 7) begin
        drain($sformatf("rnd%0d", i));
        overflow_clr = 1'b1;
        @(negedge clk);
        overflow_clr = 1'b0;
        movf = 1'b0;
      end
    end
    drain("rnd_final");

    // reset in the middle of a write with entries queued
    for (int i = 0; i < 2; i++) begin
      v = mk(16'h5000 + 16'(i), 8'h90 + 8'(i), 1'b0, 1'b1, 8, 1'b0);
      bus_cycle(v, 2'b00);
    end
    chk("prerst_level", 32'(fifo_level), 32'd2);
    @(negedge clk);
    a = 16'h5555; d_in = 8'hAA; rw = 1'b0; phi2 = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(wr_valid), 32'd0);
    chk("midrst_level", 32'(fifo_level), 32'd0);
    chk("midrst_addr", 32'(wr_addr), 32'd0);
    chk("midrst_data", 32'(wr_data), 32'd0);
    @(negedge clk);
    phi2 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rw = 1'b1;
    repeat (6) @(negedge clk);
    chk("postrst_level", 32'(fifo_level), 32'd0);
    chk("postrst_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 3; i++) begin
      v = mk(16'h6000 + 16'(i), 8'hC0 + 8'(i), 1'b0, 1'b1, 6, 1'b0);
      bus_cycle(v, 2'b00);
      chk($sformatf("postrst%0d_head", i), 32'({wr_addr, wr_data}), 32'({v.addr, v.data}));
`ifdef ATARI_WRCAP_STAMP_EN
      chk($sformatf("postrst%0d_stamp", i), 32'(wr_stamp), 32'(i));
`endif
      wr_ready = 1'b1;
      @(negedge clk);
      wr_ready = 1'b0;
    end
    chk("postrst_empty", 32'(fifo_level), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
